// File: rtl/vec_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mem_pkg
//  Description : Shared constants and FSM state encoding for the vector
//                data-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_mem_pkg;

    // Default lane count of a vector access (one lane per 32-bit word)
    localparam int c_LANES  = 5;
    // Width of one lane / one memory word
    localparam int c_WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH x WIDTH single-port word storage, synchronous write,
//                asynchronous read. Contents are intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem_q [DEPTH];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem_q[i_addr];

endmodule
`default_nettype wire

// File: rtl/vec_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mem_responder
//  Description : Load/store responder serving scalar words and LANES-word
//                vector accesses, serialised one lane per cycle over a
//                single-port word array, with a one-cycle MemReady pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_mem_responder
    import vec_mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LANES = c_LANES
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        MemReq,
    input  logic                        MemWrite,
    input  logic                        VecAccess,
    input  logic [31:0]                 Addr,
    input  logic [31:0]                 WriteData,
    input  logic [c_WORD_W*LANES-1:0]   WriteVec,
    output logic [31:0]                 ReadData,
    output logic [c_WORD_W*LANES-1:0]   ReadVec,
    output logic                        MemReady,
    output logic                        Busy,
    output logic                        AddrErr
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_VW = c_WORD_W * LANES;

    state_e              r_state_q, w_state_d;
    logic [c_LW-1:0]     r_lane_q,  w_lane_d;
    logic [c_AW-1:0]     r_base_q,  w_base_d;
    logic                r_write_q, w_write_d;
    logic [c_VW-1:0]     r_wvec_q,  w_wvec_d;
    logic [31:0]         r_rdata_q, w_rdata_d;
    logic [c_VW-1:0]     r_rvec_q,  w_rvec_d;
    logic                r_ready_q, w_ready_d;
    logic                r_busy_q,  w_busy_d;
    logic                r_err_q,   w_err_d;

    logic                w_mem_we;
    logic [c_AW-1:0]     w_mem_addr;
    logic [31:0]         w_mem_wdata;
    logic [31:0]         w_mem_rdata;

    logic [c_AW-1:0]     w_addr_idx;
    logic                w_misaligned;
    logic                w_unused_addr_hi;

    assign w_addr_idx       = Addr[2 +: c_AW];
    assign w_misaligned     = |Addr[1:0];
    // Upper address bits take no part in word selection
    assign w_unused_addr_hi = ^Addr[31:2+c_AW];

    // Next-state, array access and output-register computation
    always_comb begin
        w_state_d   = r_state_q;
        w_lane_d    = r_lane_q;
        w_base_d    = r_base_q;
        w_write_d   = r_write_q;
        w_wvec_d    = r_wvec_q;
        w_rdata_d   = r_rdata_q;
        w_rvec_d    = r_rvec_q;
        w_err_d     = r_err_q;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_base_q + c_AW'(r_lane_q);
        w_mem_wdata = WriteData;

        case (r_state_q)
            ST_IDLE: begin
                w_mem_addr = w_addr_idx;
                if (MemReq) begin
                    w_write_d = MemWrite;
                    w_base_d  = w_addr_idx;
                    w_wvec_d  = WriteVec;
                    w_lane_d  = '0;
                    if (w_misaligned) begin
                        w_rdata_d = '0;
                        w_rvec_d  = '0;
                        w_err_d   = 1'b1;
                        w_state_d = ST_DONE;
                    end else if (!VecAccess) begin
                        // Scalar access completes at the acceptance edge
                        if (MemWrite) begin
                            w_mem_we = 1'b1;
                        end else begin
                            w_rdata_d = w_mem_rdata;
                        end
                        w_state_d = ST_DONE;
                    end else begin
                        w_state_d = ST_BURST;
                    end
                end
            end
            ST_BURST: begin
                w_mem_wdata = r_wvec_q[int'(r_lane_q)*c_WORD_W +: c_WORD_W];
                if (r_write_q) begin
                    w_mem_we = 1'b1;
                end else begin
                    w_rvec_d[int'(r_lane_q)*c_WORD_W +: c_WORD_W] = w_mem_rdata;
                end
                w_lane_d = r_lane_q + c_LW'(1);
                if (r_lane_q == c_LW'(LANES-1)) begin
                    w_state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                w_err_d   = 1'b0;
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_ready_d = (w_state_d == ST_DONE);
        w_busy_d  = (w_state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any burst in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_lane_q  <= '0;
            r_base_q  <= '0;
            r_write_q <= 1'b0;
            r_wvec_q  <= '0;
            r_rdata_q <= '0;
            r_rvec_q  <= '0;
            r_ready_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_lane_q  <= w_lane_d;
            r_base_q  <= w_base_d;
            r_write_q <= w_write_d;
            r_wvec_q  <= w_wvec_d;
            r_rdata_q <= w_rdata_d;
            r_rvec_q  <= w_rvec_d;
            r_ready_q <= w_ready_d;
            r_busy_q  <= w_busy_d;
            r_err_q   <= w_err_d;
        end
    end

    // Writes are suppressed on the reset edge so an aborted burst stops cleanly
    dmem_array #(
        .DEPTH (DEPTH),
        .WIDTH (c_WORD_W)
    ) u_dmem_array (
        .clk     (clk),
        .i_we    (w_mem_we & ~reset),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign ReadData = r_rdata_q;
    assign ReadVec  = r_rvec_q;
    assign MemReady = r_ready_q;
    assign Busy     = r_busy_q;
    assign AddrErr  = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_mem_responder
//  Description : Directed, table-driven self-checking bench for
//                vec_mem_responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mem_responder;

    localparam int c_DEPTH = 64;
    localparam int c_LANES = 5;
    localparam int c_VW    = 32 * c_LANES;
    localparam int c_NVEC  = 23;

    typedef struct {
        logic            wr;
        logic            vec;
        logic [31:0]     addr;
        logic [31:0]     wdata;
        logic [c_VW-1:0] wvec;
        logic [31:0]     exp_rdata;
        logic [c_VW-1:0] exp_rvec;
        logic            exp_err;
        logic            interfere;
    } vec_t;

    logic            clk;
    logic            reset;
    logic            MemReq;
    logic            MemWrite;
    logic            VecAccess;
    logic [31:0]     Addr;
    logic [31:0]     WriteData;
    logic [c_VW-1:0] WriteVec;
    logic [31:0]     ReadData;
    logic [c_VW-1:0] ReadVec;
    logic            MemReady;
    logic            Busy;
    logic            AddrErr;

    int checks;
    int errors;
    vec_t vt [c_NVEC];

    vec_mem_responder #(
        .DEPTH (c_DEPTH),
        .LANES (c_LANES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemReq    (MemReq),
        .MemWrite  (MemWrite),
        .VecAccess (VecAccess),
        .Addr      (Addr),
        .WriteData (WriteData),
        .WriteVec  (WriteVec),
        .ReadData  (ReadData),
        .ReadVec   (ReadVec),
        .MemReady  (MemReady),
        .Busy      (Busy),
        .AddrErr   (AddrErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [c_VW-1:0] act, input logic [c_VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic vec, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [c_VW-1:0] wvec,
                                input logic [31:0] erd, input logic [c_VW-1:0] erv,
                                input logic eerr, input logic interf);
        vec_t v;
        v.wr = wr; v.vec = vec; v.addr = addr; v.wdata = wdata; v.wvec = wvec;
        v.exp_rdata = erd; v.exp_rvec = erv; v.exp_err = eerr; v.interfere = interf;
        return v;
    endfunction

    // One complete access from request to return to IDLE
    task automatic run_access(input vec_t v, input int idx);
        int lat;
        int exp_lat;
        @(negedge clk);
        MemReq = 1'b1; MemWrite = v.wr; VecAccess = v.vec;
        Addr = v.addr; WriteData = v.wdata; WriteVec = v.wvec;
        @(posedge clk); #1;
        lat = 0;
        while (MemReady !== 1'b1 && lat < c_LANES + 8) begin
            if (v.interfere && lat == 1) begin
                MemReq = 1'b0; Addr = 32'h80; MemWrite = 1'b0;
                WriteVec = ~v.wvec; WriteData = 32'hBAD0BAD0;
            end
            if (v.interfere && lat == 2) MemReq = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (v.addr[1:0] != 2'b00 || !v.vec) ? 0 : c_LANES;
        chk($sformatf("v%0d_latency", idx), c_VW'(lat), c_VW'(exp_lat));
        chk($sformatf("v%0d_addrerr", idx), c_VW'(AddrErr), c_VW'(v.exp_err));
        chk($sformatf("v%0d_rdata", idx), c_VW'(ReadData), c_VW'(v.exp_rdata));
        chk($sformatf("v%0d_rvec", idx), ReadVec, v.exp_rvec);
        chk($sformatf("v%0d_busy_done", idx), c_VW'(Busy), c_VW'(1));
        MemReq = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready_pulse", idx), c_VW'(MemReady), c_VW'(0));
        chk($sformatf("v%0d_busy_idle", idx), c_VW'(Busy), c_VW'(0));
        chk($sformatf("v%0d_err_clear", idx), c_VW'(AddrErr), c_VW'(0));
    endtask

    initial begin
        logic [c_VW-1:0] v1, v2, v3, vk, vabc, vkab;
        checks = 0;
        errors = 0;
        v1   = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        v2   = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
        v3   = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};
        vk   = {32'h74, 32'h73, 32'h72, 32'h71, 32'h70};
        vabc = {32'hE, 32'hD, 32'hC, 32'hB, 32'hA};
        vkab = {32'h74, 32'h73, 32'h72, 32'hB, 32'hA};

        //            wr    vec   addr      wdata          wvec   rdata          rvec  err   intf
        vt[0]  = mk(1'b1, 1'b0, 32'h10,  32'hDEADBEEF, '0,    32'h0,        '0,   1'b0, 1'b0);
        vt[1]  = mk(1'b0, 1'b0, 32'h10,  32'h0,        '0,    32'hDEADBEEF, '0,   1'b0, 1'b0);
        vt[2]  = mk(1'b1, 1'b1, 32'h20,  32'h0,        v1,    32'hDEADBEEF, '0,   1'b0, 1'b0);
        vt[3]  = mk(1'b0, 1'b1, 32'h20,  32'h0,        '0,    32'hDEADBEEF, v1,   1'b0, 1'b0);
        vt[4]  = mk(1'b0, 1'b0, 32'h2C,  32'h0,        '0,    32'd4,        v1,   1'b0, 1'b0);
        vt[5]  = mk(1'b1, 1'b1, 32'hF8,  32'h0,        v2,    32'd4,        v1,   1'b0, 1'b0);
        vt[6]  = mk(1'b0, 1'b0, 32'h00,  32'h0,        '0,    32'h33,       v1,   1'b0, 1'b0);
        vt[7]  = mk(1'b0, 1'b0, 32'h04,  32'h0,        '0,    32'h44,       v1,   1'b0, 1'b0);
        vt[8]  = mk(1'b0, 1'b0, 32'h08,  32'h0,        '0,    32'h55,       v1,   1'b0, 1'b0);
        vt[9]  = mk(1'b0, 1'b0, 32'hFC,  32'h0,        '0,    32'h22,       v1,   1'b0, 1'b0);
        vt[10] = mk(1'b0, 1'b0, 32'h110, 32'h0,        '0,    32'hDEADBEEF, v1,   1'b0, 1'b0);
        vt[11] = mk(1'b0, 1'b0, 32'h13,  32'h0,        '0,    32'h0,        '0,   1'b1, 1'b0);
        vt[12] = mk(1'b0, 1'b0, 32'h10,  32'h0,        '0,    32'hDEADBEEF, '0,   1'b0, 1'b0);
        vt[13] = mk(1'b1, 1'b1, 32'h21,  32'h0,        ~v1,   32'h0,        '0,   1'b1, 1'b0);
        vt[14] = mk(1'b0, 1'b1, 32'h20,  32'h0,        '0,    32'h0,        v1,   1'b0, 1'b0);
        vt[15] = mk(1'b0, 1'b1, 32'hF8,  32'h0,        '0,    32'h0,        v2,   1'b0, 1'b0);
        vt[16] = mk(1'b1, 1'b0, 32'h80,  32'h12345678, '0,    32'h0,        v2,   1'b0, 1'b0);
        vt[17] = mk(1'b1, 1'b1, 32'h40,  32'h0,        v3,    32'h0,        v2,   1'b0, 1'b1);
        vt[18] = mk(1'b0, 1'b1, 32'h40,  32'h0,        '0,    32'h0,        v3,   1'b0, 1'b0);
        vt[19] = mk(1'b0, 1'b0, 32'h80,  32'h0,        '0,    32'h12345678, v3,   1'b0, 1'b0);
        vt[20] = mk(1'b1, 1'b1, 32'h60,  32'h0,        vk,    32'h12345678, v3,   1'b0, 1'b0);
        vt[21] = mk(1'b0, 1'b1, 32'h60,  32'h0,        '0,    32'h12345678, vk,   1'b0, 1'b0);
        vt[22] = mk(1'b0, 1'b1, 32'h60,  32'h0,        '0,    32'h0,        vkab, 1'b0, 1'b0);

        reset = 1'b1; MemReq = 1'b0; MemWrite = 1'b0; VecAccess = 1'b0;
        Addr = '0; WriteData = '0; WriteVec = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_ready", c_VW'(MemReady), c_VW'(0));
        chk("reset_busy", c_VW'(Busy), c_VW'(0));
        chk("reset_err", c_VW'(AddrErr), c_VW'(0));
        chk("reset_rdata", c_VW'(ReadData), c_VW'(0));
        chk("reset_rvec", ReadVec, '0);

        for (int i = 0; i < 22; i++) begin
            run_access(vt[i], i);
        end

        // Reset lands on the lane-2 edge of a vector store to 0x60
        @(negedge clk);
        MemReq = 1'b1; MemWrite = 1'b1; VecAccess = 1'b1; Addr = 32'h60; WriteVec = vabc;
        @(posedge clk); #1;
        MemReq = 1'b0;
        chk("abort_busy_burst", c_VW'(Busy), c_VW'(1));
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", c_VW'(MemReady), c_VW'(0));
        chk("abort_busy", c_VW'(Busy), c_VW'(0));
        chk("abort_err", c_VW'(AddrErr), c_VW'(0));
        chk("abort_rdata", c_VW'(ReadData), c_VW'(0));
        chk("abort_rvec", ReadVec, '0);

        run_access(vt[22], 22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vec_mem_responder.md
# vec_mem_responder

Data-memory responder at the far end of the processor's load/store port. Serves 32-bit scalar accesses and 5-lane vector accesses (one lane per 32-bit word, matching the vector register file lane count) through a request/ready handshake. Vector transfers are serialized one lane per cycle over a single-port word array. Sits between the datapath's ALUResult/WriteData/ReadData path and on-chip storage.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words; power of two.
- LANES, 5: lanes per vector access.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; the only reset.
- MemReq  in  1  request valid; sampled only in IDLE.
- MemWrite  in  1  1 = store, 0 = load.
- VecAccess  in  1  1 = LANES-word vector access, 0 = scalar.
- Addr  in  32  byte address of word (lane 0 for vectors).
- WriteData  in  32  scalar store data.
- WriteVec  in  32*LANES  vector store data; lane i at [32i+31:32i].
- ReadData  out  32  scalar load result.
- ReadVec  out  32*LANES  vector load result, same lane packing.
- MemReady  out  1  one-cycle completion pulse; load data valid while high.
- Busy  out  1  high in BURST and DONE.
- AddrErr  out  1  high with MemReady when Addr[1:0] != 0.

## Operation
- States: IDLE, BURST, DONE.
- IDLE, MemReq=0: hold. MemReq=1: latch MemWrite, VecAccess, Addr, WriteData, WriteVec; clear lane counter.
  - Addr[1:0] != 0: no array access, ReadData/ReadVec cleared to 0, AddrErr set, go DONE.
  - Scalar: perform access at acceptance edge (store writes word; load registers word into ReadData), go DONE.
  - Vector: go BURST.
- BURST: each cycle handle lane = counter at word index (base + lane) mod DEPTH; store writes WriteVec lane; load registers word into ReadVec lane. Counter increments; after lane LANES-1, go DONE.
- DONE: MemReady=1 for exactly one cycle, then IDLE. AddrErr cleared on leaving DONE.
- Word index = Addr[2 +: log2(DEPTH)]; upper address bits ignored; vector lanes wrap modulo DEPTH.
- MemReq outside IDLE is ignored; requester holds request until MemReady. Inputs changing after acceptance have no effect.
- ReadData/ReadVec hold their last value until the next load or error overwrites them; store does not alter them.
- Array contents are not reset.
- Reset mid-burst: abort to IDLE; lanes already written stay written, remaining lanes not written.

## Timing
- Reset values: state IDLE, MemReady 0, Busy 0, AddrErr 0, ReadData 0, ReadVec 0, counter 0.
- Scalar or misaligned: accepted at edge N; MemReady high in cycle after N; IDLE after edge N+1. Earliest next acceptance at edge N+2.
- Vector: accepted at edge N; lane k handled at edge N+1+k; DONE after edge N+LANES; MemReady high in that cycle; IDLE after edge N+LANES+1. Total LANES+2 cycles.
- Load data combinationally from array, registered into output at the access edge; no output is combinational from inputs.

## Structure
- Package vec_mem_pkg: LANES default, state enum (IDLE/BURST/DONE), lane-slice width constant 32.
- Sub-module dmem_array: DEPTH×32 single-port storage, synchronous write, asynchronous read; FSM and counter live in vec_mem_responder.

## Test plan
- Scalar store 0xDEADBEEF at Addr 0x10, then scalar load 0x10 -> MemReady one cycle after each acceptance; ReadData=0xDEADBEEF; AddrErr=0.
- Vector store lanes {1,2,3,4,5} at Addr 0x20, then vector load -> MemReady 6 cycles after acceptance; ReadVec lanes = 1..5; scalar load 0x2C returns 4.
- Vector store at Addr 4*(DEPTH-2) -> lanes 2..4 land in words 0..2 (wrap); scalar loads confirm.
- Load at Addr 0x13 -> AddrErr=1 and MemReady=1 in same cycle; ReadData=0; no array change.
- MemReq pulsed and Addr changed during BURST -> ignored; original burst completes unaltered.
- Reset asserted at lane 2 of vector store of {A,B,C,D,E} -> IDLE next cycle, outputs at reset values; words 0–1 of burst hold A,B, words 2–4 unchanged.
